// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared types and constants for the L1-to-L2 port arbiter.
package l2_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;
   localparam int ADDR_W = 26;
endpackage

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the L2 request port between L1 I-cache and D-cache controllers.
// ARB_ROUND_ROBIN_EN selects a rotating tie-break; otherwise D wins every tie.
module l2_port_arbiter #(
   parameter int ADDR_W = l2_arb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_read_req,
   input  logic              i_write_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   input  logic              d_read_req,
   input  logic              d_write_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_ready,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   input  logic              l2_ready,
   output logic              l2_src
);
   import l2_arb_pkg::*;

   state_t state_q, state_d;
   logic   pend_i, pend_d, win_d, gnt_i, gnt_d;

   always_comb begin
      pend_i = i_read_req | i_write_req;
      pend_d = d_read_req | d_write_req;
      gnt_i  = state_q == GRANT_I;
      gnt_d  = state_q == GRANT_D;
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) ptr_q <= SRC_I;
      else       ptr_q <= ptr_d;

   // Each completion hands the next tie to the other side.
   always_comb begin
      ptr_d = (gnt_i && l2_ready) ? SRC_D : (gnt_d && l2_ready) ? SRC_I : ptr_q;
      win_d = pend_d && (!pend_i || ptr_q == SRC_D);
   end
`else
   always_comb win_d = pend_d;
`endif

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = win_d ? GRANT_D : pend_i ? GRANT_I : IDLE;
         GRANT_I: state_d = l2_ready ? RELEASE : pend_i ? GRANT_I : IDLE;
         GRANT_D: state_d = l2_ready ? RELEASE : pend_d ? GRANT_D : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A write-back takes precedence over a read from the same requester.
   always_comb begin
      l2_write = (gnt_i & i_write_req) | (gnt_d & d_write_req);
      l2_read  = (gnt_i & i_read_req & ~i_write_req) | (gnt_d & d_read_req & ~d_write_req);
      l2_addr  = gnt_i ? i_addr : gnt_d ? d_addr : '0;
      l2_src   = gnt_d ? SRC_D : SRC_I;
      i_ready  = gnt_i & l2_ready;
      d_ready  = gnt_d & l2_ready;
   end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed and random checks of l2_port_arbiter against a grant-owner model.
module tb_l2_port_arbiter;
   logic        clk = 1'b0;
   logic        nrst;
   logic        i_read_req, i_write_req, d_read_req, d_write_req, l2_ready;
   logic [25:0] i_addr, d_addr;
   logic        i_ready, d_ready, l2_read, l2_write, l2_src;
   logic [25:0] l2_addr;

   int n_chk = 0;
   int n_fail = 0;
   int owner = -1;
   bit rel = 1'b0;
   bit ptr = 1'b0;
   bit e_ir, e_dr;

   always #5 clk = ~clk;

   l2_port_arbiter dut (
      .clk(clk), .nrst(nrst),
      .i_read_req(i_read_req), .i_write_req(i_write_req), .i_addr(i_addr), .i_ready(i_ready),
      .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr), .d_ready(d_ready),
      .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_ready(l2_ready),
      .l2_src(l2_src)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_l2_read"}, l2_read, 0);
      chk({tag, "_l2_write"}, l2_write, 0);
      chk({tag, "_l2_addr"}, l2_addr, 0);
      chk({tag, "_l2_src"}, l2_src, 0);
      chk({tag, "_i_ready"}, i_ready, 0);
      chk({tag, "_d_ready"}, d_ready, 0);
   endtask

   // One cycle: drive at negedge, check mid-phase, advance model at posedge.
   task automatic step(input bit ir, input bit iw, input logic [25:0] ia,
                       input bit dr, input bit dw, input logic [25:0] da, input bit rdy);
      bit pi, pd, tie_d;
      i_read_req = ir; i_write_req = iw; i_addr = ia;
      d_read_req = dr; d_write_req = dw; d_addr = da;
      l2_ready = rdy;
      #1;
      e_ir = (owner == 0) && rdy;
      e_dr = (owner == 1) && rdy;
      chk("l2_src", l2_src, owner == 1);
      chk("l2_addr", l2_addr, owner == 0 ? ia : owner == 1 ? da : 26'd0);
      chk("l2_write", l2_write, owner == 0 ? iw : owner == 1 ? dw : 1'b0);
      chk("l2_read", l2_read, owner == 0 ? (ir && !iw) : owner == 1 ? (dr && !dw) : 1'b0);
      chk("i_ready", i_ready, e_ir);
      chk("d_ready", d_ready, e_dr);
      @(posedge clk);
      pi = ir | iw;
      pd = dr | dw;
`ifdef ARB_ROUND_ROBIN_EN
      tie_d = ptr;
`else
      tie_d = 1'b1;
`endif
      if (rel) rel = 1'b0;
      else if (owner < 0) owner = (pi && pd) ? int'(tie_d) : pi ? 0 : pd ? 1 : -1;
      else if (rdy) begin
         rel = 1'b1;
         ptr = (owner == 0);
         owner = -1;
      end else if (!(owner == 0 ? pi : pd)) owner = -1;
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      nrst = 1'b0;
      #1;
      chk_zero(tag);
      owner = -1; rel = 1'b0; ptr = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      bit ir, iw, dr, dw;
      logic [25:0] ia, da;
      i_read_req = 0; i_write_req = 0; d_read_req = 0; d_write_req = 0;
      i_addr = '0; d_addr = '0; l2_ready = 0; nrst = 1'b1;
      @(negedge clk);
      do_reset("reset");
      // I read 0x00ABC, L2 answers after a few cycles
      step(1, 0, 26'h00ABC, 0, 0, 0, 0);
      repeat (3) step(1, 0, 26'h00ABC, 0, 0, 0, 0);
      step(1, 0, 26'h00ABC, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // I read and D write raised together after reset
      do_reset("reset2");
      repeat (3) step(1, 0, 26'h0111, 0, 1, 26'h2222, 0);
      step(1, 0, 26'h0111, 0, 1, 26'h2222, 1);
      repeat (3) step(0, 0, 0, 0, 1, 26'h2222, 0);
      step(0, 0, 0, 0, 1, 26'h2222, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      // back-to-back ties
      do_reset("reset3");
      repeat (4) begin
         step(1, 0, 26'h3A, 1, 0, 26'h3B, 0);
         step(1, 0, 26'h3A, 1, 0, 26'h3B, 1);
         step(1, 0, 26'h3A, 1, 0, 26'h3B, 0);
      end
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // D write-back plus read, then the remaining read
      repeat (3) step(0, 0, 0, 1, 1, 26'h1555, 0);
      step(0, 0, 0, 1, 1, 26'h1555, 1);
      repeat (2) step(0, 0, 0, 1, 0, 26'h1555, 0);
      step(0, 0, 0, 1, 0, 26'h1555, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      // spurious ready while idle, then an aborted I request
      repeat (2) step(0, 0, 0, 0, 0, 0, 1);
      repeat (2) step(1, 0, 26'h77, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // reset in the middle of a D grant
      repeat (2) step(0, 0, 0, 1, 0, 26'h3FFFFFF, 0);
      do_reset("mid_reset");
      step(0, 0, 0, 0, 0, 0, 0);
      // random requesters that hold until ready, with occasional aborts
      ir = 0; iw = 0; dr = 0; dw = 0; ia = '0; da = '0;
      repeat (400) begin
         if (e_ir || ((ir | iw) && $urandom_range(15) == 0)) begin ir = 0; iw = 0; end
         else if (!(ir | iw) && $urandom_range(2) == 0) begin
            ir = $urandom_range(1); iw = !ir | ($urandom_range(3) == 0); ia = 26'($urandom);
         end
         if (e_dr || ((dr | dw) && $urandom_range(15) == 0)) begin dr = 0; dw = 0; end
         else if (!(dr | dw) && $urandom_range(2) == 0) begin
            dr = $urandom_range(1); dw = !dr | ($urandom_range(3) == 0); da = 26'($urandom);
         end
         step(ir, iw, ia, dr, dw, da, $urandom_range(2) == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
